// File: rtl/tt_um_leg_solver.sv
// Right-triangle leg solver: given hypotenuse c and leg a, computes b = floor(sqrt(c*c - a*a))
// with a bit-serial square root (one result bit per cycle, MSB first).
module tt_um_leg_solver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    // state  | meaning
    // IDLE   | waiting for loads / start pulse
    // SQUARE | range check, form c*c - a*a
    // ROOT   | 8 bit-serial root iterations, n = 7..0
    // DONE   | result held, loads and new start accepted
    typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;

    state_t      state;
    logic [7:0]  c_reg;
    logic [7:0]  a_reg;
    logic [7:0]  root;
    logic [15:0] diff;
    logic [2:0]  n;
    logic        start_q;
    logic        busy;
    logic        done;
    logic        err;

    logic        load_c;
    logic        load_a;
    logic        start;
    logic        start_pulse;
    logic        accept_start;
    logic [7:0]  trial;
    logic [15:0] trial_sq;
    logic [7:0]  root_next;
    logic [15:0] diff_next;
    logic        unused_uio;

    assign load_c      = uio_in[0];
    assign load_a      = uio_in[1];
    assign start       = uio_in[2];
    assign unused_uio  = &{1'b0, uio_in[7:3]};
    assign start_pulse = start & ~start_q;
    assign accept_start = start_pulse & ~load_c & ~load_a;

    always_comb begin
        trial     = root | (8'd1 << n);
        trial_sq  = {8'd0, trial} * {8'd0, trial};
        root_next = (trial_sq <= diff) ? trial : root;
        diff_next = ({8'd0, c_reg} * {8'd0, c_reg}) - ({8'd0, a_reg} * {8'd0, a_reg});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            c_reg   <= '0;
            a_reg   <= '0;
            diff    <= '0;
            root    <= '0;
            n       <= '0;
            start_q <= 1'b0;
            uo_out  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else if (ena) begin
            start_q <= start;
            case (state)
                IDLE, DONE: begin
                    if (load_c) c_reg <= ui_in;
                    if (load_a) a_reg <= ui_in;
                    if (accept_start) begin
                        state <= SQUARE;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                SQUARE: begin
                    if (a_reg > c_reg) begin
                        state  <= DONE;
                        uo_out <= '0;
                        err    <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        diff  <= diff_next;
                        root  <= '0;
                        n     <= 3'd7;
                        state <= ROOT;
                    end
                end
                ROOT: begin
                    root <= root_next;
                    if (n == 3'd0) begin
                        uo_out <= root_next;
                        state  <= DONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        n <= n - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign uio_out = {1'b0, err, done, busy, 4'b0000};
    assign uio_oe  = 8'b0111_0000;

endmodule
